// File: rtl/dmem_arbiter.sv
// ============================================================================
// Module   : dmem_arbiter
// Brief    : Two-port arbiter and access sequencer for the FIR 2560x16 data
//            memory; round-robin arbitration enabled by DMEM_ARB_ROUND_ROBIN_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module dmem_arbiter #(
  parameter int AW    = 12,
  parameter int DW    = 16,
  parameter int DEPTH = 2560
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0_valid_i,
  output logic          req0_ready_o,
  input  logic          req0_we_i,
  input  logic [AW-1:0] req0_addr_i,
  input  logic [DW-1:0] req0_wdata_i,
  output logic [DW-1:0] req0_rdata_o,
  output logic          req0_rvalid_o,
  output logic          req0_err_o,
  input  logic          req1_valid_i,
  output logic          req1_ready_o,
  input  logic          req1_we_i,
  input  logic [AW-1:0] req1_addr_i,
  input  logic [DW-1:0] req1_wdata_i,
  output logic [DW-1:0] req1_rdata_o,
  output logic          req1_rvalid_o,
  output logic          req1_err_o,
  output logic          mem_cen_o,
  output logic          mem_wen_o,
  output logic [AW-1:0] mem_a_o,
  output logic [DW-1:0] mem_d_o,
  input  logic [DW-1:0] mem_q_i
);

  localparam logic [AW:0] c_depth = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          mem_cen_q, mem_cen_d;
  logic          mem_wen_q, mem_wen_d;
  logic [AW-1:0] mem_a_q, mem_a_d;
  logic [DW-1:0] mem_d_q, mem_d_d;
  logic          owner_q, owner_d;
  logic          op_we_q, op_we_d;
  logic [DW-1:0] rdata0_q, rdata0_d;
  logic [DW-1:0] rdata1_q, rdata1_d;
  logic          rvalid0_q, rvalid0_d;
  logic          rvalid1_q, rvalid1_d;
  logic          err0_q, err0_d;
  logic          err1_q, err1_d;

  logic          w_grant;
  logic          w_sel_valid;
  logic          w_sel_we;
  logic [AW-1:0] w_sel_addr;
  logic [DW-1:0] w_sel_wdata;
  logic          w_in_range;
  logic          w_accept;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
  logic last_q, last_d;

  // On contention the port that was not served last wins; pointer resets to 1.
  assign w_grant = req1_valid_i & (~req0_valid_i | ~last_q);
  assign last_d  = w_accept ? w_grant : last_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_q <= 1'b1;
    else        last_q <= last_d;
  end
`else
  assign w_grant = req1_valid_i & ~req0_valid_i;
`endif

  assign w_sel_valid = w_grant ? req1_valid_i : req0_valid_i;
  assign w_sel_we    = w_grant ? req1_we_i    : req0_we_i;
  assign w_sel_addr  = w_grant ? req1_addr_i  : req0_addr_i;
  assign w_sel_wdata = w_grant ? req1_wdata_i : req0_wdata_i;
  assign w_in_range  = {1'b0, w_sel_addr} < c_depth;
  assign w_accept    = (state_q == ST_IDLE) && w_sel_valid;

  always_comb begin
    state_d   = state_q;
    mem_cen_d = mem_cen_q;
    mem_wen_d = mem_wen_q;
    mem_a_d   = mem_a_q;
    mem_d_d   = mem_d_q;
    owner_d   = owner_q;
    op_we_d   = op_we_q;
    rdata0_d  = rdata0_q;
    rdata1_d  = rdata1_q;
    rvalid0_d = 1'b0;
    rvalid1_d = 1'b0;
    err0_d    = 1'b0;
    err1_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (w_accept) begin
          if (w_in_range) begin
            mem_a_d   = w_sel_addr;
            mem_d_d   = w_sel_wdata;
            mem_wen_d = ~w_sel_we;
            mem_cen_d = 1'b0;
            owner_d   = w_grant;
            op_we_d   = w_sel_we;
            state_d   = ST_ISSUE;
          end else if (w_grant) begin
            err1_d = 1'b1;
          end else begin
            err0_d = 1'b1;
          end
        end
      end
      ST_ISSUE: begin
        mem_cen_d = 1'b1;
        mem_wen_d = 1'b1;
        state_d   = op_we_q ? ST_IDLE : ST_CAPTURE;
      end
      ST_CAPTURE: begin
        // mem_a stays put: the bank output mux is still selecting on it.
        if (owner_q) begin
          rdata1_d  = mem_q_i;
          rvalid1_d = 1'b1;
        end else begin
          rdata0_d  = mem_q_i;
          rvalid0_d = 1'b1;
        end
        state_d = ST_IDLE;
      end
      default: begin
        mem_cen_d = 1'b1;
        mem_wen_d = 1'b1;
        state_d   = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      mem_cen_q <= 1'b1;
      mem_wen_q <= 1'b1;
      mem_a_q   <= '0;
      mem_d_q   <= '0;
      owner_q   <= 1'b0;
      op_we_q   <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      err0_q    <= 1'b0;
      err1_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mem_cen_q <= mem_cen_d;
      mem_wen_q <= mem_wen_d;
      mem_a_q   <= mem_a_d;
      mem_d_q   <= mem_d_d;
      owner_q   <= owner_d;
      op_we_q   <= op_we_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
      err0_q    <= err0_d;
      err1_q    <= err1_d;
    end
  end

  assign req0_ready_o  = (state_q == ST_IDLE) && !w_grant;
  assign req1_ready_o  = (state_q == ST_IDLE) &&  w_grant;
  assign req0_rdata_o  = rdata0_q;
  assign req1_rdata_o  = rdata1_q;
  assign req0_rvalid_o = rvalid0_q;
  assign req1_rvalid_o = rvalid1_q;
  assign req0_err_o    = err0_q;
  assign req1_err_o    = err1_q;
  assign mem_cen_o     = mem_cen_q;
  assign mem_wen_o     = mem_wen_q;
  assign mem_a_o       = mem_a_q;
  assign mem_d_o       = mem_d_q;

endmodule

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
// ============================================================================
// Module   : tb_dmem_arbiter
// Brief    : Self-checking bench for dmem_arbiter with a behavioural memory and
//            transaction-level reference model (DMEM_ARB_ROUND_ROBIN_EN aware).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_dmem_arbiter;
  localparam int AW    = 12;
  localparam int DW    = 16;
  localparam int DEPTH = 2560;

  logic          clk;
  logic          rst_n;
  logic          req0_valid, req0_ready, req0_we, req0_rvalid, req0_err;
  logic [AW-1:0] req0_addr;
  logic [DW-1:0] req0_wdata, req0_rdata;
  logic          req1_valid, req1_ready, req1_we, req1_rvalid, req1_err;
  logic [AW-1:0] req1_addr;
  logic [DW-1:0] req1_wdata, req1_rdata;
  logic          mem_cen, mem_wen;
  logic [AW-1:0] mem_a;
  logic [DW-1:0] mem_d, mem_q;

  dmem_arbiter #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid_i(req0_valid), .req0_ready_o(req0_ready), .req0_we_i(req0_we),
    .req0_addr_i(req0_addr), .req0_wdata_i(req0_wdata), .req0_rdata_o(req0_rdata),
    .req0_rvalid_o(req0_rvalid), .req0_err_o(req0_err),
    .req1_valid_i(req1_valid), .req1_ready_o(req1_ready), .req1_we_i(req1_we),
    .req1_addr_i(req1_addr), .req1_wdata_i(req1_wdata), .req1_rdata_o(req1_rdata),
    .req1_rvalid_o(req1_rvalid), .req1_err_o(req1_err),
    .mem_cen_o(mem_cen), .mem_wen_o(mem_wen), .mem_a_o(mem_a), .mem_d_o(mem_d),
    .mem_q_i(mem_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural 2560x16 memory: write on the enabled edge, combinational read mux.
  logic [DW-1:0] tb_mem [0:DEPTH-1];
  always @(posedge clk)
    if (!mem_cen && !mem_wen && (mem_a < AW'(DEPTH))) tb_mem[mem_a] <= mem_d;
  assign mem_q = (mem_a < AW'(DEPTH)) ? tb_mem[mem_a] : 16'hDEAD;

  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] ref_mem   [0:DEPTH-1];
  bit            written   [0:DEPTH-1];
  logic [DW-1:0] ref_rdata [2];
  int            tb_last;

  bit            timed_out;
  logic [3:1]    o_cen, o_wen, o_err, o_rv, o_oth;
  logic [AW-1:0] o_a [1:3];
  logic [DW-1:0] o_d1, o_rd;

  task automatic drive(input int p, input logic v, input logic we,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (p == 0) begin
      req0_valid = v; req0_we = we; req0_addr = a; req0_wdata = d;
    end else begin
      req1_valid = v; req1_we = we; req1_addr = a; req1_wdata = d;
    end
  endtask

  function automatic logic rdy(input int p);
    return (p == 0) ? req0_ready : req1_ready;
  endfunction

  // Handshake one request and record three cycles of DUT behaviour after accept.
  task automatic run_txn(input int p, input logic we, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
    int w;
    w = 0;
    timed_out = 1'b0;
    @(negedge clk);
    drive(p, 1'b1, we, a, d);
    #1;
    while (!rdy(p)) begin
      if (w == 20) begin
        timed_out = 1'b1;
        break;
      end
      @(negedge clk);
      #1;
      w++;
    end
    if (!timed_out) begin
      tb_last = p;
      @(negedge clk);
      for (int c = 1; c <= 3; c++) begin
        if (c > 1) @(negedge clk);
        o_cen[c] = mem_cen;
        o_wen[c] = mem_wen;
        o_a[c]   = mem_a;
        o_err[c] = (p == 0) ? req0_err : req1_err;
        o_rv[c]  = (p == 0) ? req0_rvalid : req1_rvalid;
        o_oth[c] = (p == 0) ? (req1_rvalid | req1_err) : (req0_rvalid | req0_err);
        if (c == 1) begin
          o_d1 = mem_d;
          drive(p, 1'b0, 1'b0, '0, '0);
        end
        if (c == 3) o_rd = (p == 0) ? req0_rdata : req1_rdata;
      end
    end
    drive(p, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);
    tb_last = 1;
    ref_rdata[0] = '0;
    ref_rdata[1] = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    checks++; if ({mem_cen, mem_wen} !== 2'b11) begin errors++; $display("FAIL reset_cen_wen got=%b exp=11", {mem_cen, mem_wen}); end
    checks++; if (mem_a !== '0) begin errors++; $display("FAIL reset_mem_a got=%h exp=0", mem_a); end
    checks++; if (mem_d !== '0) begin errors++; $display("FAIL reset_mem_d got=%h exp=0", mem_d); end
    checks++; if (req0_rdata !== '0) begin errors++; $display("FAIL reset_rdata0 got=%h exp=0", req0_rdata); end
    checks++; if (req1_rdata !== '0) begin errors++; $display("FAIL reset_rdata1 got=%h exp=0", req1_rdata); end
    checks++; if ({req0_rvalid, req1_rvalid, req0_err, req1_err} !== 4'b0) begin errors++;
      $display("FAIL reset_pulses got=%b exp=0000", {req0_rvalid, req1_rvalid, req0_err, req1_err}); end
    checks++; if (req1_ready !== 1'b0) begin errors++; $display("FAIL reset_ready1 got=%b exp=0", req1_ready); end
  endtask

  task automatic test_write_read;
    int            ports [8] = '{0, 0, 0, 1, 0, 1, 0, 1};
    bit            wes   [8] = '{1, 0, 1, 1, 1, 0, 0, 0};
    int            addrs [8] = '{'h105, 'h105, 'h0FF, 'h100, 'h9FF, 'h0FF, 'h100, 'h9FF};
    int            datas [8] = '{'hBEEF, 0, 'h1111, 'h2222, 'h3333, 0, 0, 0};
    int            pool  [6] = '{'h105, 'h0FF, 'h100, 'h9FF, 'h000, 'h7A3};
    int            p;
    logic          we;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    for (int i = 0; i < 40; i++) begin
      if (i < 8) begin
        p = ports[i]; we = wes[i]; a = AW'(addrs[i]); d = DW'(datas[i]);
      end else begin
        p  = int'($urandom_range(0, 1));
        we = 1'($urandom_range(0, 1));
        a  = AW'(pool[$urandom_range(0, 5)]);
        d  = DW'($urandom);
        if (!written[a]) we = 1'b1;
      end
      run_txn(p, we, a, d);
      checks++; if (timed_out) begin errors++; $display("FAIL wr_accept_timeout txn=%0d port=%0d", i, p); continue; end
      checks++; if (o_cen !== 3'b110) begin errors++; $display("FAIL wr_cen_seq txn=%0d got=%b exp=110", i, o_cen); end
      checks++; if (o_wen[1] !== ~we || o_wen[2] !== 1'b1) begin errors++;
        $display("FAIL wr_wen txn=%0d got=%b exp=%b1", i, o_wen[2:1], ~we); end
      checks++; if (o_a[1] !== a) begin errors++; $display("FAIL wr_mem_a txn=%0d got=%h exp=%h", i, o_a[1], a); end
      checks++; if (o_err !== 3'b000 || o_oth !== 3'b000) begin errors++;
        $display("FAIL wr_no_err txn=%0d err=%b other=%b exp=000", i, o_err, o_oth); end
      if (we) begin
        ref_mem[a] = d;
        written[a] = 1'b1;
        checks++; if (o_d1 !== d) begin errors++; $display("FAIL wr_mem_d txn=%0d got=%h exp=%h", i, o_d1, d); end
        checks++; if (tb_mem[a] !== d) begin errors++; $display("FAIL wr_mem_content txn=%0d got=%h exp=%h", i, tb_mem[a], d); end
        checks++; if (o_rv !== 3'b000) begin errors++; $display("FAIL wr_no_rvalid txn=%0d got=%b exp=000", i, o_rv); end
      end else begin
        ref_rdata[p] = ref_mem[a];
        checks++; if (o_a[2] !== a) begin errors++; $display("FAIL rd_addr_held txn=%0d got=%h exp=%h", i, o_a[2], a); end
        checks++; if (o_rv !== 3'b100) begin errors++; $display("FAIL rd_rvalid_timing txn=%0d got=%b exp=100", i, o_rv); end
        checks++; if (o_rd !== ref_mem[a]) begin errors++; $display("FAIL rd_data txn=%0d port=%0d got=%h exp=%h", i, p, o_rd, ref_mem[a]); end
      end
    end
  endtask

  task automatic test_out_of_range;
    int            p;
    logic [AW-1:0] a;
    for (int i = 0; i < 8; i++) begin
      p = (i < 2) ? 1 : int'($urandom_range(0, 1));
      a = (i == 0) ? AW'('hA00) : (i == 1) ? AW'('hFFF) : AW'($urandom_range(DEPTH, 4095));
      run_txn(p, (i < 2) ? 1'b0 : 1'($urandom_range(0, 1)), a, DW'($urandom));
      checks++; if (timed_out) begin errors++; $display("FAIL oor_accept_timeout txn=%0d port=%0d", i, p); continue; end
      checks++; if (o_err !== 3'b001) begin errors++; $display("FAIL oor_err_pulse txn=%0d addr=%h got=%b exp=001", i, a, o_err); end
      checks++; if (o_cen !== 3'b111) begin errors++; $display("FAIL oor_cen_idle txn=%0d got=%b exp=111", i, o_cen); end
      checks++; if (o_rv !== 3'b000) begin errors++; $display("FAIL oor_no_rvalid txn=%0d got=%b exp=000", i, o_rv); end
      checks++; if (o_rd !== ref_rdata[p]) begin errors++; $display("FAIL oor_rdata_kept txn=%0d got=%h exp=%h", i, o_rd, ref_rdata[p]); end
    end
  endtask

  task automatic test_contention;
    logic [AW-1:0] a0, a1;
    logic [DW-1:0] q0 [$];
    logic [DW-1:0] q1 [$];
    int            n_acc, acc, exp_p;
    logic          v0, v1;
    a0 = AW'('h105);
    a1 = AW'('h0FF);
    n_acc = 0;
    for (int cyc = 0; cyc < 80; cyc++) begin
      @(negedge clk);
      v0 = (n_acc < 6);
      v1 = (n_acc < 7);
      drive(0, v0, 1'b0, a0, '0);
      drive(1, v1, 1'b0, a1, '0);
      #1;
      if (req0_ready && req1_ready) begin
        checks++; errors++; $display("FAIL cont_ready_onehot cyc=%0d got=11 exp=one-hot", cyc);
      end
      acc = (v0 && req0_ready) ? 0 : (v1 && req1_ready) ? 1 : -1;
      if (acc >= 0) begin
`ifdef DMEM_ARB_ROUND_ROBIN_EN
        exp_p = (v0 && v1) ? ((tb_last == 0) ? 1 : 0) : (v0 ? 0 : 1);
`else
        exp_p = v0 ? 0 : 1;
`endif
        checks++; if (acc != exp_p) begin errors++; $display("FAIL cont_grant acc#%0d got=%0d exp=%0d", n_acc, acc, exp_p); end
        tb_last = acc;
        if (acc == 0) q0.push_back(ref_mem[a0]); else q1.push_back(ref_mem[a1]);
        n_acc++;
      end
      if (req0_rvalid) begin
        checks++;
        if (q0.size() == 0) begin errors++; $display("FAIL cont_rvalid0 unexpected got=1 exp=0"); end
        else begin
          if (req0_rdata !== q0[0]) begin errors++; $display("FAIL cont_rdata0 got=%h exp=%h", req0_rdata, q0[0]); end
          ref_rdata[0] = q0.pop_front();
        end
      end
      if (req1_rvalid) begin
        checks++;
        if (q1.size() == 0) begin errors++; $display("FAIL cont_rvalid1 unexpected got=1 exp=0"); end
        else begin
          if (req1_rdata !== q1[0]) begin errors++; $display("FAIL cont_rdata1 got=%h exp=%h", req1_rdata, q1[0]); end
          ref_rdata[1] = q1.pop_front();
        end
      end
      if (n_acc == 7 && q0.size() == 0 && q1.size() == 0) break;
    end
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);
    checks++; if (n_acc != 7 || q0.size() != 0 || q1.size() != 0) begin errors++;
      $display("FAIL cont_complete accepts=%0d pend=%0d exp accepts=7 pend=0", n_acc, q0.size() + q1.size()); end
  endtask

  task automatic test_reset_mid_op;
    int            p;
    logic [AW-1:0] a;
    int            w;
    for (int phase = 1; phase <= 2; phase++) begin
      p = (phase == 1) ? 1 : 0;
      a = (phase == 1) ? AW'('h100) : AW'('h105);
      @(negedge clk);
      drive(p, 1'b1, 1'b0, a, '0);
      #1;
      w = 0;
      while (!rdy(p) && w < 20) begin @(negedge clk); #1; w++; end
      checks++; if (w == 20) begin errors++; $display("FAIL rst_accept_timeout phase=%0d", phase); end
      @(negedge clk);
      drive(p, 1'b0, 1'b0, '0, '0);
      if (phase == 2) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      checks++; if (mem_cen !== 1'b1) begin errors++; $display("FAIL rst_async_cen phase=%0d got=%b exp=1", phase, mem_cen); end
      checks++; if ({req0_rvalid, req1_rvalid} !== 2'b00) begin errors++;
        $display("FAIL rst_async_rvalid phase=%0d got=%b exp=00", phase, {req0_rvalid, req1_rvalid}); end
      checks++; if (req0_rdata !== '0 || req1_rdata !== '0) begin errors++;
        $display("FAIL rst_async_rdata phase=%0d got=%h/%h exp=0/0", phase, req0_rdata, req1_rdata); end
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      ref_rdata[0] = '0;
      ref_rdata[1] = '0;
      tb_last = 1;
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        checks++; if (req0_rvalid || req1_rvalid || !mem_cen) begin errors++;
          $display("FAIL rst_no_stale phase=%0d cyc=%0d rvalid=%b cen=%b exp rvalid=00 cen=1", phase, c, {req0_rvalid, req1_rvalid}, mem_cen); end
      end
      run_txn(p, 1'b0, a, '0);
      checks++; if (timed_out) begin errors++; $display("FAIL rst_post_timeout phase=%0d", phase); continue; end
      ref_rdata[p] = ref_mem[a];
      checks++; if (o_rv !== 3'b100) begin errors++; $display("FAIL rst_post_rvalid phase=%0d got=%b exp=100", phase, o_rv); end
      checks++; if (o_rd !== ref_mem[a]) begin errors++; $display("FAIL rst_post_rdata phase=%0d got=%h exp=%h", phase, o_rd, ref_mem[a]); end
    end
  endtask

  task automatic test_back_to_back;
    logic [DW-1:0] bd [10];
    int            idx;
    for (int i = 0; i < 10; i++) bd[i] = DW'($urandom);
    repeat (3) @(negedge clk);
    idx = 0;
    for (int cyc = 0; cyc < 40 && idx < 10; cyc++) begin
      drive(1, 1'b1, 1'b1, AW'(idx), bd[idx]);
      drive(0, 1'b0, 1'b0, '0, '0);
      #1;
      checks++; if (req1_ready !== ((cyc % 2) == 0)) begin errors++;
        $display("FAIL b2b_ready cyc=%0d got=%b exp=%b", cyc, req1_ready, ((cyc % 2) == 0)); end
      if (req1_ready) begin
        ref_mem[idx] = bd[idx];
        written[idx] = 1'b1;
        tb_last = 1;
        idx++;
      end
      @(negedge clk);
    end
    drive(1, 1'b0, 1'b0, '0, '0);
    repeat (2) @(negedge clk);
    checks++; if (idx != 10) begin errors++; $display("FAIL b2b_count got=%0d exp=10", idx); end
    for (int i = 0; i < 10; i++) begin
      checks++; if (tb_mem[i] !== ref_mem[i]) begin errors++;
        $display("FAIL b2b_dump addr=%0d got=%h exp=%h", i, tb_mem[i], ref_mem[i]); end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_write_read();
    test_out_of_range();
    test_contention();
    test_reset_mid_op();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
